// File: rtl/ddr_axi_pkg.sv
// Shared defaults, master-index type and the round-robin pick helper
// used by the two-master DDR AXI arbiter.
package ddr_axi_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int ID_W_DEF   = 4;
  localparam int FIFO_DEPTH = 4;

  typedef logic mst_idx_t;

  // On a tie the master that was not granted last wins.
  function automatic mst_idx_t rr_pick(input logic i_v0, input logic i_v1,
                                       input mst_idx_t i_last);
    mst_idx_t w_sel;
    if (i_v0 && i_v1) w_sel = ~i_last;
    else              w_sel = i_v1;
    return w_sel;
  endfunction

endpackage

// File: rtl/axi_order_fifo.sv
// Write-order FIFO: remembers which master owns each granted AW so the
// W channel can be steered to the right source in address order.
module axi_order_fifo
  import ddr_axi_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  mst_idx_t i_din,
  input  logic     i_pop,
  output mst_idx_t o_dout,
  output logic     o_full,
  output logic     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  mst_idx_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/ddr_axi_arbiter.sv
// Two-master to one-slave AXI arbiter in front of the DDR3 controller:
// registered round-robin AR/AW, ID-based R/B routing, W ordered by AW grants.
module ddr_axi_arbiter
  import ddr_axi_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W   = ID_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // master 0
  input  logic              s0_arvalid,
  input  logic [ID_W-2:0]   s0_arid,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic [1:0]        s0_arburst,
  output logic              s0_arready,
  output logic              s0_rvalid,
  output logic [ID_W-2:0]   s0_rid,
  output logic [DATA_W-1:0] s0_rdata,
  output logic              s0_rlast,
  output logic [1:0]        s0_rresp,
  input  logic              s0_rready,
  input  logic              s0_awvalid,
  input  logic [ID_W-2:0]   s0_awid,
  input  logic [ADDR_W-1:0] s0_awaddr,
  input  logic [7:0]        s0_awlen,
  input  logic [1:0]        s0_awburst,
  output logic              s0_awready,
  input  logic              s0_wvalid,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic              s0_wlast,
  output logic              s0_wready,
  output logic              s0_bvalid,
  output logic [ID_W-2:0]   s0_bid,
  output logic [1:0]        s0_bresp,
  input  logic              s0_bready,
  // master 1
  input  logic              s1_arvalid,
  input  logic [ID_W-2:0]   s1_arid,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic [1:0]        s1_arburst,
  output logic              s1_arready,
  output logic              s1_rvalid,
  output logic [ID_W-2:0]   s1_rid,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s1_rlast,
  output logic [1:0]        s1_rresp,
  input  logic              s1_rready,
  input  logic              s1_awvalid,
  input  logic [ID_W-2:0]   s1_awid,
  input  logic [ADDR_W-1:0] s1_awaddr,
  input  logic [7:0]        s1_awlen,
  input  logic [1:0]        s1_awburst,
  output logic              s1_awready,
  input  logic              s1_wvalid,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic              s1_wlast,
  output logic              s1_wready,
  output logic              s1_bvalid,
  output logic [ID_W-2:0]   s1_bid,
  output logic [1:0]        s1_bresp,
  input  logic              s1_bready,
  // downstream DDR controller
  output logic              m_arvalid,
  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [1:0]        m_arburst,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  input  logic [1:0]        m_rresp,
  output logic              m_rready,
  output logic              m_awvalid,
  output logic [ID_W-1:0]   m_awid,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic [1:0]        m_awburst,
  input  logic              m_awready,
  output logic              m_wvalid,
  output logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic              m_wlast,
  input  logic              m_wready,
  input  logic              m_bvalid,
  input  logic [ID_W-1:0]   m_bid,
  input  logic [1:0]        m_bresp,
  output logic              m_bready
);

  // ---------------- AR: one-entry register, round-robin grant
  mst_idx_t          w_ar_sel;
  logic              w_ar_load;
  logic              r_ar_vld_p0;
  mst_idx_t          r_ar_last;
  logic [ID_W-1:0]   r_ar_id_p0;
  logic [ADDR_W-1:0] r_ar_addr_p0;
  logic [7:0]        r_ar_len_p0;
  logic [1:0]        r_ar_burst_p0;

  assign w_ar_sel   = rr_pick(s0_arvalid, s1_arvalid, r_ar_last);
  assign w_ar_load  = !i_rst && (s0_arvalid || s1_arvalid) && (!r_ar_vld_p0 || m_arready);
  assign s0_arready = w_ar_load && (w_ar_sel == 1'b0);
  assign s1_arready = w_ar_load && (w_ar_sel == 1'b1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ar_vld_p0 <= 1'b0;
      r_ar_last   <= 1'b1;
    end else if (w_ar_load) begin
      r_ar_vld_p0 <= 1'b1;
      r_ar_last   <= w_ar_sel;
    end else if (m_arready) begin
      r_ar_vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_ar_load) begin
      r_ar_id_p0    <= {w_ar_sel, (w_ar_sel ? s1_arid : s0_arid)};
      r_ar_addr_p0  <= w_ar_sel ? s1_araddr  : s0_araddr;
      r_ar_len_p0   <= w_ar_sel ? s1_arlen   : s0_arlen;
      r_ar_burst_p0 <= w_ar_sel ? s1_arburst : s0_arburst;
    end
  end

  assign m_arvalid = r_ar_vld_p0;
  assign m_arid    = r_ar_id_p0;
  assign m_araddr  = r_ar_addr_p0;
  assign m_arlen   = r_ar_len_p0;
  assign m_arburst = r_ar_burst_p0;

  // ---------------- AW: same as AR, gated by write-order FIFO space
  mst_idx_t          w_aw_sel;
  logic              w_aw_load;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  mst_idx_t          w_fifo_head;
  logic              w_fifo_pop;
  logic              r_aw_vld_p0;
  mst_idx_t          r_aw_last;
  logic [ID_W-1:0]   r_aw_id_p0;
  logic [ADDR_W-1:0] r_aw_addr_p0;
  logic [7:0]        r_aw_len_p0;
  logic [1:0]        r_aw_burst_p0;

  // Full blocks the grant even when a pop lands in the same cycle.
  assign w_aw_sel   = rr_pick(s0_awvalid, s1_awvalid, r_aw_last);
  assign w_aw_load  = !i_rst && !w_fifo_full && (s0_awvalid || s1_awvalid) &&
                      (!r_aw_vld_p0 || m_awready);
  assign s0_awready = w_aw_load && (w_aw_sel == 1'b0);
  assign s1_awready = w_aw_load && (w_aw_sel == 1'b1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_aw_vld_p0 <= 1'b0;
      r_aw_last   <= 1'b1;
    end else if (w_aw_load) begin
      r_aw_vld_p0 <= 1'b1;
      r_aw_last   <= w_aw_sel;
    end else if (m_awready) begin
      r_aw_vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_aw_load) begin
      r_aw_id_p0    <= {w_aw_sel, (w_aw_sel ? s1_awid : s0_awid)};
      r_aw_addr_p0  <= w_aw_sel ? s1_awaddr  : s0_awaddr;
      r_aw_len_p0   <= w_aw_sel ? s1_awlen   : s0_awlen;
      r_aw_burst_p0 <= w_aw_sel ? s1_awburst : s0_awburst;
    end
  end

  assign m_awvalid = r_aw_vld_p0;
  assign m_awid    = r_aw_id_p0;
  assign m_awaddr  = r_aw_addr_p0;
  assign m_awlen   = r_aw_len_p0;
  assign m_awburst = r_aw_burst_p0;

  axi_order_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_order_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_aw_load),
    .i_din   (w_aw_sel),
    .i_pop   (w_fifo_pop),
    .o_dout  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // ---------------- W: steered from the master at the FIFO head
  assign m_wvalid   = !w_fifo_empty && (w_fifo_head ? s1_wvalid : s0_wvalid);
  assign m_wdata    = w_fifo_head ? s1_wdata : s0_wdata;
  assign m_wstrb    = w_fifo_head ? s1_wstrb : s0_wstrb;
  assign m_wlast    = w_fifo_head ? s1_wlast : s0_wlast;
  assign s0_wready  = !w_fifo_empty && !w_fifo_head && m_wready;
  assign s1_wready  = !w_fifo_empty &&  w_fifo_head && m_wready;
  assign w_fifo_pop = m_wvalid && m_wready && m_wlast;

  // ---------------- R / B: routed on the top ID bit
  assign s0_rvalid = m_rvalid && !m_rid[ID_W-1];
  assign s1_rvalid = m_rvalid &&  m_rid[ID_W-1];
  assign m_rready  = m_rid[ID_W-1] ? s1_rready : s0_rready;
  assign s0_rid    = m_rid[ID_W-2:0];
  assign s1_rid    = m_rid[ID_W-2:0];
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;

  assign s0_bvalid = m_bvalid && !m_bid[ID_W-1];
  assign s1_bvalid = m_bvalid &&  m_bid[ID_W-1];
  assign m_bready  = m_bid[ID_W-1] ? s1_bready : s0_bready;
  assign s0_bid    = m_bid[ID_W-2:0];
  assign s1_bid    = m_bid[ID_W-2:0];
  assign s0_bresp  = m_bresp;
  assign s1_bresp  = m_bresp;

endmodule

// File: doc/ddr_axi_arbiter.md
DDR_AXI_ARBITER -- requirements
Module: ddr_axi_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named i_clk and i_rst.
REQ-002 Parameter ADDR_W, default 32: AXI address width.
REQ-003 Parameter DATA_W, default 32: AXI data width; wstrb is DATA_W/8.
REQ-004 Parameter ID_W, default 4: downstream ID width; each upstream ID is ID_W-1 bits.
REQ-005 Port i_clk, input, 1: controller clock.
REQ-006 Port i_rst, input, 1: synchronous active-high reset.
REQ-007 Ports s{0,1}_ar{valid,id,addr,len,burst}, input, {1,ID_W-1,ADDR_W,8,2}: read-address channel from master 0/1.
REQ-008 Ports s{0,1}_arready, output, 1: read-address accept to master 0/1.
REQ-009 Ports s{0,1}_r{valid,id,data,last,resp}, output, {1,ID_W-1,DATA_W,1,2}: read data to master 0/1.
REQ-010 Ports s{0,1}_rready, input, 1: read-data accept from master 0/1.
REQ-011 Ports s{0,1}_aw{valid,id,addr,len,burst}, input: write-address channel from master 0/1, widths as AR.
REQ-012 Ports s{0,1}_awready, output, 1: write-address accept to master 0/1.
REQ-013 Ports s{0,1}_w{valid,data,strb,last}, input, {1,DATA_W,DATA_W/8,1}: write data from master 0/1.
REQ-014 Ports s{0,1}_wready, output, 1: write-data accept to master 0/1.
REQ-015 Ports s{0,1}_b{valid,id,resp}, output, {1,ID_W-1,2}: write response to master 0/1.
REQ-016 Ports s{0,1}_bready, input, 1: write-response accept from master 0/1.
REQ-017 Ports m_ar*, m_r*, m_aw*, m_w*, m_b*: single AXI master port to the DDR3 controller, directions mirrored, IDs ID_W bits.

Function
REQ-018 AR path SHALL use a one-entry output register; m_arvalid SHALL rise exactly 1 cycle after s_arvalid is captured.
REQ-019 The AR register SHALL load when it is empty or m_arvalid&m_arready in the same cycle; the winner sees s_arready=1 in the load cycle only.
REQ-020 AR grant SHALL be round-robin: on a tie the master not granted last wins; the pointer updates only on a grant.
REQ-021 m_arid SHALL be {master_index, s_arid}; addr, len and burst SHALL pass unchanged.
REQ-022 R routing SHALL be combinational on m_rid[ID_W-1]: the selected s_rvalid=m_rvalid, m_rready=that master's s_rready, s_rid=m_rid[ID_W-2:0]; the other master's s_rvalid=0.
REQ-023 AW path SHALL behave as REQ-018..021 and additionally push the granted index into a 4-deep write-order FIFO.
REQ-024 No AW grant SHALL occur while the FIFO is full, even if a pop happens in the same cycle.
REQ-025 W SHALL pass combinationally from the master at the FIFO head; the other master's s_wready=0. When the FIFO is empty, m_wvalid=0 and both s_wready=0.
REQ-026 The FIFO SHALL pop on m_wvalid&m_wready&m_wlast; a push into an empty FIFO SHALL enable W from the next cycle.
REQ-027 B routing SHALL be on m_bid[ID_W-1], analogous to REQ-022.
REQ-028 Multiple outstanding reads and writes SHALL be allowed; ordering within a master is left to the downstream ID rules.

Reset
REQ-029 On i_rst, m_arvalid, m_awvalid, all s_arready and all s_awready SHALL be 0, the FIFO SHALL be empty, and both RR pointers SHALL give master 0 priority.
REQ-030 Reset mid-burst SHALL abandon all in-flight state; no pending transfer is replayed.

Structure
REQ-031 Package ddr_axi_pkg SHALL hold ADDR_W/DATA_W/ID_W defaults, the master-index type and the FIFO depth constant.
REQ-032 The write-order FIFO SHALL be a sub-module, axi_order_fifo (depth 4, 1-bit entries, full/empty flags).

Verification
REQ-033 Both masters assert arvalid in the same cycle after reset -> m_arid=4'b0xxx first, then 4'b1xxx; pointer alternates.
REQ-034 m_arready held 0 for 5 cycles -> m_arvalid and m_araddr stable, no s_arready pulse.
REQ-035 m_rid=4'b1010, rvalid=1 -> s1_rvalid=1, s1_rid=3'b010, s0_rvalid=0 in the same cycle.
REQ-036 M0 AW len=3, then M1 AW len=0 -> exactly 4 W beats from M0, then 1 beat from M1; s1_wready=0 until M0's wlast.
REQ-037 5 AW requests with m_wready=0 -> 4 granted, the 5th stalls until the first wlast pops the FIFO.
REQ-038 i_rst asserted during a W burst -> the next cycle has all valids/readies per REQ-029 and an empty FIFO.
